// File: rtl/wb_arb_pkg.sv
// Shared encodings and default widths for the two-requester Wishbone arbiter.
package wb_arb_pkg;

    localparam int DEF_AW = 15;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick: the pointer breaks ties, a lone requester always wins.
module rr_pick2
    import wb_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt,
    output logic       o_id
);

    assign o_id  = (&i_req) ? i_ptr : (i_req[1] ? ID_M1 : ID_M0);
    assign o_gnt = {(|i_req) & o_id, (|i_req) & ~o_id};

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between m0 (spif bridge) and m1 (DMA/debug).
// Define WB_ARB_TIMEOUT_EN to add a watchdog that ends hung cycles with a one-cycle error strobe.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int TOUT_BITS = 8
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat,
    input  logic          m0_we,
    input  logic          m0_stb,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat,
    input  logic          m1_we,
    input  logic          m1_stb,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m_dat,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we,
    output logic          s_stb,
    input  logic          s_ack,
    input  logic [DW-1:0] s_dat_i,
    output logic [1:0]    owner
);

    generate
        if (TOUT_BITS < 1) begin : g_bad_tout
            $error("wb_arbiter: TOUT_BITS must be at least 1");
        end
    endgenerate

    state_t        r_state;
    logic          r_ptr;
    logic [AW-1:0] r_s_adr;
    logic [DW-1:0] r_s_dat;
    logic          r_s_we;

    logic [1:0]    w_gnt;
    logic          w_id;
    logic          w_busy;
    logic          w_own;
    logic          w_own_stb;
    logic          w_tout;

    rr_pick2 u_pick (
        .i_req ({m1_stb, m0_stb}),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_id)
    );

    assign w_busy    = (r_state != ST_IDLE);
    assign w_own     = (r_state == ST_BUSY1);
    assign w_own_stb = w_own ? m1_stb : m0_stb;

    // Request fields are latched at grant, so mid-cycle changes never reach the slave.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_ptr   <= ID_M0;
            r_s_adr <= '0;
            r_s_dat <= '0;
            r_s_we  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_state <= (w_id == ID_M1) ? ST_BUSY1 : ST_BUSY0;
                        r_s_adr <= (w_id == ID_M1) ? m1_adr : m0_adr;
                        r_s_dat <= (w_id == ID_M1) ? m1_dat : m0_dat;
                        r_s_we  <= (w_id == ID_M1) ? m1_we  : m0_we;
                    end
                end
                ST_BUSY0, ST_BUSY1: begin
                    if (s_ack || w_tout) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= ~w_own;
                    end else if (!w_own_stb) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Expire in the cycle that would bring the count of un-acked BUSY cycles to all-ones.
    localparam logic [TOUT_BITS-1:0] WDT_LAST = ~TOUT_BITS'(1);
    logic [TOUT_BITS-1:0] r_wdt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wdt <= '0;
        end else if (!w_busy) begin
            r_wdt <= '0;
        end else if (!s_ack) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    assign w_tout = w_busy & w_own_stb & ~s_ack & (r_wdt == WDT_LAST);
`else
    assign w_tout = 1'b0;
`endif

    assign s_stb   = w_busy & w_own_stb & ~w_tout;
    assign s_adr   = r_s_adr;
    assign s_dat_o = r_s_dat;
    assign s_we    = r_s_we;

    assign m0_ack  = (r_state == ST_BUSY0) & s_ack;
    assign m1_ack  = (r_state == ST_BUSY1) & s_ack;
    assign m0_err  = (r_state == ST_BUSY0) & w_tout;
    assign m1_err  = (r_state == ST_BUSY1) & w_tout;

    assign m_dat   = s_dat_i;
    assign owner   = {w_busy, w_own};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: requests push expected completions, slave acks pop and compare them.
module tb_wb_arbiter;

    logic        clk, arst;
    logic [14:0] m0_adr, m1_adr, s_adr;
    logic [31:0] m0_dat, m1_dat, m_dat, s_dat_o, s_dat_i;
    logic        m0_we, m0_stb, m0_ack, m0_err;
    logic        m1_we, m1_stb, m1_ack, m1_err;
    logic        s_we, s_stb, s_ack;
    logic [1:0]  owner;

    wb_arbiter #(.AW(15), .DW(32), .TOUT_BITS(4)) dut (
        .clk(clk), .arst(arst),
        .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_we(m0_we), .m0_stb(m0_stb),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_we(m1_we), .m1_stb(m1_stb),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .m_dat(m_dat), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_we(s_we),
        .s_stb(s_stb), .s_ack(s_ack), .s_dat_i(s_dat_i), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [14:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   early;
    int   n0, n1;
    logic got;

    function automatic logic [31:0] rd_of(input logic [14:0] adr);
        return (adr == 15'h0123) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(adr));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic req(input logic id, input logic [14:0] adr, input logic we, input logic [31:0] wd);
        exp_t e;
        if (id) begin
            m1_adr = adr; m1_we = we; m1_dat = wd; m1_stb = 1'b1;
        end else begin
            m0_adr = adr; m0_we = we; m0_dat = wd; m0_stb = 1'b1;
        end
        e.id = id; e.adr = adr; e.we = we; e.wdat = wd; e.rdat = rd_of(adr);
        sb_q.push_back(e);
    endtask

    task automatic wait_sstb();
        int n;
        n = 0;
        while (!s_stb && n < 20) begin
            tick();
            n++;
        end
        chk("s_stb_wait", 64'(s_stb), 64'(1));
    endtask

    task automatic check_ack();
        exp_t e;
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("ack_vec", 64'({m1_ack, m0_ack}), e.id ? 64'(2'b10) : 64'(2'b01));
            chk("ack_adr", 64'(s_adr), 64'(e.adr));
            chk("ack_we", 64'(s_we), 64'(e.we));
            if (e.we) chk("ack_wdat", 64'(s_dat_o), 64'(e.wdat));
            else      chk("ack_rdat", 64'(m_dat), 64'(e.rdat));
        end
    endtask

    // Slave model: ack lat cycles after s_stb first appears, returning address-derived data.
    task automatic serve(input int lat, output logic id);
        wait_sstb();
        repeat (lat) tick();
        s_ack = 1'b1;
        s_dat_i = rd_of(s_adr);
        #1;
        id = m1_ack;
        check_ack();
        tick();
        s_ack = 1'b0;
        s_dat_i = '0;
    endtask

    initial begin
        arst = 1'b0;
        idle_inputs();
        #1 arst = 1'b1;
        #1;
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_sbus", 64'({s_stb, s_we, s_adr, s_dat_o}), 64'(0));
        chk("rst_ackerr", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;

        // m0 read with three-cycle slave latency
        tick();
        req(1'b0, 15'h0123, 1'b0, 32'h0);
        #1;
        chk("t1_lat_n", 64'(s_stb), 64'(0));
        tick();
        chk("t1_lat_n1", 64'(s_stb), 64'(1));
        chk("t1_owner", 64'(owner), 64'(2'b10));
        serve(3, got);
        m0_stb = 1'b0;
        chk("t1_ack_pulse", 64'({m0_ack, m1_ack}), 64'(0));
        chk("t1_idle", 64'(owner), 64'(0));

        // simultaneous requests from reset alternate m0,m1,m0,m1 with an idle cycle between
        do_reset();
        tick();
        req(1'b0, 15'h0010, 1'b0, 32'h0);
        req(1'b1, 15'h0020, 1'b0, 32'h0);
        n0 = 1; n1 = 1;
        for (int t = 0; t < 4; t++) begin
            serve(1, got);
            chk("t2_order", 64'(got), 64'(t % 2));
            chk("t2_idle_owner", 64'(owner), 64'(0));
            chk("t2_idle_stb", 64'(s_stb), 64'(0));
            if (got) begin
                if (n1 < 2) begin req(1'b1, 15'h0021, 1'b0, 32'h0); n1++; end
                else m1_stb = 1'b0;
            end else begin
                if (n0 < 2) begin req(1'b0, 15'h0011, 1'b0, 32'h0); n0++; end
                else m0_stb = 1'b0;
            end
        end

        // m1 write; latched fields hold even when the master's inputs move
        tick();
        req(1'b1, 15'h7FFF, 1'b1, 32'h12345678);
        tick();
        chk("t3_owner", 64'(owner), 64'(2'b11));
        chk("t3_fields", 64'({s_we, s_adr, s_dat_o}), {16'h0, 1'b1, 15'h7FFF, 32'h12345678});
        m1_adr = 15'h0000;
        m1_dat = 32'h0;
        tick();
        chk("t3_hold", 64'({s_we, s_adr, s_dat_o}), {16'h0, 1'b1, 15'h7FFF, 32'h12345678});
        s_ack = 1'b1;
        #1;
        check_ack();
        tick();
        s_ack = 1'b0;
        m1_stb = 1'b0;

        // m0 abort after two BUSY cycles; pointer must stay on m0
        tick();
        m0_adr = 15'h0042; m0_we = 1'b0; m0_stb = 1'b1;
        tick();
        chk("t4_busy", 64'(owner), 64'(2'b10));
        tick();
        m0_stb = 1'b0;
        #1;
        chk("t4_stb_drop", 64'(s_stb), 64'(0));
        tick();
        chk("t4_idle", 64'(owner), 64'(0));
        req(1'b0, 15'h0043, 1'b0, 32'h0);
        req(1'b1, 15'h0044, 1'b0, 32'h0);
        serve(1, got);
        chk("t4_ptr_m0", 64'(got), 64'(0));
        m0_stb = 1'b0;
        serve(1, got);
        m1_stb = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
        // hung slave: m0 errors in BUSY cycle 15, then the waiting m1 is granted
        tick();
        m0_adr = 15'h0050; m0_we = 1'b0; m0_stb = 1'b1;
        req(1'b1, 15'h0055, 1'b0, 32'h0);
        wait_sstb();
        early = 0;
        for (int k = 1; k < 15; k++) begin
            early += int'(m0_err);
            tick();
        end
        chk("t5_err_early", 64'(early), 64'(0));
        chk("t5_m0_err", 64'(m0_err), 64'(1));
        chk("t5_stb_off", 64'(s_stb), 64'(0));
        chk("t5_m1_err", 64'(m1_err), 64'(0));
        tick();
        m0_stb = 1'b0;
        chk("t5_err_pulse", 64'(m0_err), 64'(0));
        chk("t5_idle", 64'(owner), 64'(0));
        serve(1, got);
        chk("t5_m1_next", 64'(got), 64'(1));
        m1_stb = 1'b0;
`else
        // hung slave without watchdog: bus stays held, no error strobes
        tick();
        m0_adr = 15'h0050; m0_we = 1'b0; m0_stb = 1'b1;
        wait_sstb();
        early = 0;
        for (int k = 0; k < 20; k++) begin
            early += int'(m0_err | m1_err);
            tick();
        end
        chk("t5_no_err", 64'(early), 64'(0));
        chk("t5_held", 64'({owner, s_stb}), 64'(3'b101));
        m0_stb = 1'b0;
        tick();
        chk("t5_idle", 64'(owner), 64'(0));
`endif

        // reset while m1 owns the bus with an ack arriving
        tick();
        m1_adr = 15'h0666; m1_dat = 32'hCAFE0001; m1_we = 1'b1; m1_stb = 1'b1;
        wait_sstb();
        chk("t6_owner", 64'(owner), 64'(2'b11));
        #1 arst = 1'b1;
        #1;
        chk("t6_async", 64'({owner, s_stb, s_we, s_adr, s_dat_o}), 64'(0));
        s_ack = 1'b1;
        #1;
        chk("t6_no_ack", 64'({m1_ack, m1_err, m0_ack, m0_err}), 64'(0));
        s_ack = 1'b0;
        m1_stb = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        tick();
        chk("t6_after", 64'(owner), 64'(0));
        chk("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
